// File: rtl/ddr2_write_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_write_arbiter
//
// Purpose
//   Shares one DDR2 write path (address FIFO + write-data FIFO) between two
//   write clients:
//     client 0 : frame-fill engine
//     client 1 : line/rectangle engine
//   Each client writes two-beat bursts:
//     beat 1 : cK_af_wr_en=1 and cK_wdf_wr_en=1 in the same cycle
//     beat 2 : cK_wdf_wr_en=1 with cK_af_wr_en=0
//   A grant is locked from beat 1 until beat 2 is accepted, so the two
//   beats of a burst always land in the DDR2 FIFOs back to back with no
//   interleaving from the other client.
//
// Handshake
//   A client's full view (cK_af_full / cK_wdf_full) acts as the inverse of
//   a ready. A beat is transferred in any cycle where the client holds its
//   write enables high and its full view is low. A client that does not own
//   or win the path sees both full flags forced high, so it simply holds
//   its beat until it is granted. The DDR2 write enables are only raised
//   for a beat that is actually transferred, never while a DDR2 FIFO is
//   full.
//
// Configuration
//   ARB_FIXED_PRIORITY_EN : when defined, client 0 always wins simultaneous
//                           requests. When undefined (default), simultaneous
//                           requests are resolved round-robin against the
//                           last client that completed a burst.
//
// Ports
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   cK_af_addr_din        : client K burst address           (ADDR_W)
//   cK_af_wr_en           : client K address write enable
//   cK_wdf_din            : client K write data               (DATA_W)
//   cK_wdf_mask_din       : client K byte mask                (MASK_W)
//   cK_wdf_wr_en          : client K data write enable
//   cK_af_full            : address-FIFO full view for client K
//   cK_wdf_full           : data-FIFO full view for client K
//   af_full, wdf_full     : full flags from the DDR2 FIFOs
//   af_addr_din, af_wr_en : DDR2 address FIFO write side
//   wdf_din, wdf_mask_din,
//   wdf_wr_en             : DDR2 write-data FIFO write side
//   proto_err             : sticky, set when the owner raises af_wr_en
//                           during beat 2
//   dbg_state             : 0 = IDLE, 1 = BEAT2
//   dbg_owner             : client holding the current/last grant
//   dbg_last_served       : client that completed the most recent burst
// ---------------------------------------------------------------------------
module ddr2_write_arbiter #(
    parameter int ADDR_W = 31,
    parameter int DATA_W = 128,
    parameter int MASK_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    // client 0 (frame fill)
    input  logic [ADDR_W-1:0] c0_af_addr_din,
    input  logic              c0_af_wr_en,
    input  logic [DATA_W-1:0] c0_wdf_din,
    input  logic [MASK_W-1:0] c0_wdf_mask_din,
    input  logic              c0_wdf_wr_en,
    output logic              c0_af_full,
    output logic              c0_wdf_full,

    // client 1 (line / rectangle)
    input  logic [ADDR_W-1:0] c1_af_addr_din,
    input  logic              c1_af_wr_en,
    input  logic [DATA_W-1:0] c1_wdf_din,
    input  logic [MASK_W-1:0] c1_wdf_mask_din,
    input  logic              c1_wdf_wr_en,
    output logic              c1_af_full,
    output logic              c1_wdf_full,

    // DDR2 FIFOs
    input  logic              af_full,
    input  logic              wdf_full,
    output logic [ADDR_W-1:0] af_addr_din,
    output logic              af_wr_en,
    output logic [DATA_W-1:0] wdf_din,
    output logic [MASK_W-1:0] wdf_mask_din,
    output logic              wdf_wr_en,

    // status / debug
    output logic              proto_err,
    output logic              dbg_state,
    output logic              dbg_owner,
    output logic              dbg_last_served
);

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT2 = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q,  last_d;
    logic   perr_q,  perr_d;

    logic   c0_req, c1_req;
    logic   sel_valid;      // some client is routed to the DDR2 side
    logic   sel;            // which client is routed (0/1)
    logic   fifo_ready;
    logic   own_af, own_wdf;

    // A request needs both enables: af_wr_en alone is not a burst start.
    assign c0_req     = c0_af_wr_en & c0_wdf_wr_en;
    assign c1_req     = c1_af_wr_en & c1_wdf_wr_en;
    assign fifo_ready = !af_full && !wdf_full;

    // Owner's enables, used only in BEAT2.
    assign own_af  = owner_q ? c1_af_wr_en  : c0_af_wr_en;
    assign own_wdf = owner_q ? c1_wdf_wr_en : c0_wdf_wr_en;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;    // client 0 gets the first round-robin turn
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            perr_q  <= perr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state, selection and DDR2 write enables
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        perr_d    = perr_q;
        sel_valid = 1'b0;
        sel       = owner_q;
        af_wr_en  = 1'b0;
        wdf_wr_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (c0_req || c1_req) begin
                    sel_valid = 1'b1;
                    if (c0_req && c1_req) begin
`ifdef ARB_FIXED_PRIORITY_EN
                        sel = 1'b0;
`else
                        sel = ~last_q;
`endif
                    end else begin
                        sel = c1_req;
                    end
                    if (fifo_ready) begin
                        af_wr_en  = 1'b1;
                        wdf_wr_en = 1'b1;
                        owner_d   = sel;
                        state_d   = BEAT2;
                    end
                end
            end

            BEAT2: begin
                // Grant stays locked on the owner until its beat 2 lands.
                sel_valid = 1'b1;
                sel       = owner_q;
                if (own_af) begin
                    perr_d = 1'b1;
                end
                // A stray af_wr_en is ignored: the cycle still counts as
                // beat 2 and only the data FIFO is written.
                if (own_wdf && fifo_ready) begin
                    wdf_wr_en = 1'b1;
                    last_d    = owner_q;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Keep DDR2 quiet for the whole reset assertion, including the
        // cycle in which reset lands in the middle of a burst.
        if (!rst_n) begin
            af_wr_en  = 1'b0;
            wdf_wr_en = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Data path routing (zero latency)
    // -----------------------------------------------------------------------
    always_comb begin
        af_addr_din  = '0;
        wdf_din      = '0;
        wdf_mask_din = '1;      // all bytes masked when nothing is routed
        if (sel_valid) begin
            if (sel) begin
                af_addr_din  = c1_af_addr_din;
                wdf_din      = c1_wdf_din;
                wdf_mask_din = c1_wdf_mask_din;
            end else begin
                af_addr_din  = c0_af_addr_din;
                wdf_din      = c0_wdf_din;
                wdf_mask_din = c0_wdf_mask_din;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Client full views
    // -----------------------------------------------------------------------
    // With no selection both clients see the true FIFO state so that a
    // client waiting for !full before starting a burst is never starved.
    always_comb begin
        c0_af_full  = af_full;
        c0_wdf_full = wdf_full;
        c1_af_full  = af_full;
        c1_wdf_full = wdf_full;
        if (!rst_n) begin
            c0_af_full  = 1'b1;
            c0_wdf_full = 1'b1;
            c1_af_full  = 1'b1;
            c1_wdf_full = 1'b1;
        end else if (sel_valid) begin
            if (sel) begin
                c0_af_full  = 1'b1;
                c0_wdf_full = 1'b1;
            end else begin
                c1_af_full  = 1'b1;
                c1_wdf_full = 1'b1;
            end
        end
    end

    assign proto_err       = perr_q;
    assign dbg_state       = (state_q == BEAT2);
    assign dbg_owner       = owner_q;
    assign dbg_last_served = last_q;

endmodule

// File: tb/tb_ddr2_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr2_write_arbiter
//
// Bench for ddr2_write_arbiter. Each expected DDR2 write is pushed into
// exp_q when the beat is driven; the write monitor pops and compares every
// cycle in which the DUT raises a DDR2 write enable. Scenario tasks check
// grants, full views, state and proto_err inline.
// ---------------------------------------------------------------------------
module tb_ddr2_write_arbiter;

    localparam int ADDR_W = 31;
    localparam int DATA_W = 128;
    localparam int MASK_W = 16;
    // {af_wr_en, wdf_wr_en, addr (zero on beat 2), data, mask}
    localparam int EW     = 2 + ADDR_W + DATA_W + MASK_W;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] c0_af_addr_din, c1_af_addr_din;
    logic              c0_af_wr_en, c1_af_wr_en;
    logic [DATA_W-1:0] c0_wdf_din, c1_wdf_din;
    logic [MASK_W-1:0] c0_wdf_mask_din, c1_wdf_mask_din;
    logic              c0_wdf_wr_en, c1_wdf_wr_en;
    logic              c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full;
    logic              af_full, wdf_full;
    logic [ADDR_W-1:0] af_addr_din;
    logic              af_wr_en;
    logic [DATA_W-1:0] wdf_din;
    logic [MASK_W-1:0] wdf_mask_din;
    logic              wdf_wr_en;
    logic              proto_err, dbg_state, dbg_owner, dbg_last_served;

    ddr2_write_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .c0_af_addr_din  (c0_af_addr_din),
        .c0_af_wr_en     (c0_af_wr_en),
        .c0_wdf_din      (c0_wdf_din),
        .c0_wdf_mask_din (c0_wdf_mask_din),
        .c0_wdf_wr_en    (c0_wdf_wr_en),
        .c0_af_full      (c0_af_full),
        .c0_wdf_full     (c0_wdf_full),
        .c1_af_addr_din  (c1_af_addr_din),
        .c1_af_wr_en     (c1_af_wr_en),
        .c1_wdf_din      (c1_wdf_din),
        .c1_wdf_mask_din (c1_wdf_mask_din),
        .c1_wdf_wr_en    (c1_wdf_wr_en),
        .c1_af_full      (c1_af_full),
        .c1_wdf_full     (c1_wdf_full),
        .af_full         (af_full),
        .wdf_full        (wdf_full),
        .af_addr_din     (af_addr_din),
        .af_wr_en        (af_wr_en),
        .wdf_din         (wdf_din),
        .wdf_mask_din    (wdf_mask_din),
        .wdf_wr_en       (wdf_wr_en),
        .proto_err       (proto_err),
        .dbg_state       (dbg_state),
        .dbg_owner       (dbg_owner),
        .dbg_last_served (dbg_last_served)
    );

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [EW-1:0] mon_obs, mon_exp;

    always @(negedge clk) begin
        if (af_wr_en || wdf_wr_en) begin
            mon_obs = {af_wr_en, wdf_wr_en,
                       (af_wr_en ? af_addr_din : {ADDR_W{1'b0}}),
                       wdf_din, wdf_mask_din};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got %h want no write", mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_obs !== mon_exp) begin
                    n_err++;
                    $display("FAIL wr_beat: got %h want %h", mon_obs, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_c0(input logic af, input logic wdf,
                            input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d,
                            input logic [MASK_W-1:0] m);
        c0_af_wr_en = af; c0_wdf_wr_en = wdf;
        c0_af_addr_din = a; c0_wdf_din = d; c0_wdf_mask_din = m;
    endtask

    task automatic drive_c1(input logic af, input logic wdf,
                            input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d,
                            input logic [MASK_W-1:0] m);
        c1_af_wr_en = af; c1_wdf_wr_en = wdf;
        c1_af_addr_din = a; c1_wdf_din = d; c1_wdf_mask_din = m;
    endtask

    task automatic clear_clients();
        drive_c0(1'b0, 1'b0, '0, '0, '0);
        drive_c1(1'b0, 1'b0, '0, '0, '0);
    endtask

    // Expected DDR2 write; beat 2 carries no address.
    task automatic exp_push(input logic af, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d,
                            input logic [MASK_W-1:0] m);
        exp_q.push_back({af, 1'b1, (af ? a : {ADDR_W{1'b0}}), d, m});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_clients();
        af_full = 1'b0; wdf_full = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return DATA_W'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [MASK_W-1:0] rand_mask();
        return MASK_W'($urandom_range(0, 16'hFFFF));
    endfunction

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        af_full = 1'b0; wdf_full = 1'b0;
        drive_c0(1'b1, 1'b1, 31'h10, rand_data(), rand_mask());
        drive_c1(1'b1, 1'b1, 31'h20, rand_data(), rand_mask());
        @(negedge clk);
        n_cmp++;
        if ({af_wr_en, wdf_wr_en} !== 2'b00) begin
            n_err++; $display("FAIL rst_wr_en: got %b want 00", {af_wr_en, wdf_wr_en});
        end
        n_cmp++;
        if ({c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full} !== 4'b1111) begin
            n_err++; $display("FAIL rst_fulls: got %b want 1111",
                              {c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full});
        end
        n_cmp++;
        if ({proto_err, dbg_state, dbg_owner, dbg_last_served} !== 4'b0001) begin
            n_err++; $display("FAIL rst_state: got %b want 0001",
                              {proto_err, dbg_state, dbg_owner, dbg_last_served});
        end
        step();
        clear_clients();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_client();
        logic [DATA_W-1:0] da, db;
        logic [MASK_W-1:0] ma, mb;
        logic [ADDR_W+DATA_W+MASK_W-1:0] idle_exp;
        da = rand_data(); db = rand_data(); ma = rand_mask(); mb = rand_mask();
        // beat 1
        drive_c0(1'b1, 1'b1, 31'h100, da, ma);
        exp_push(1'b1, 31'h100, da, ma);
        @(negedge clk);
        n_cmp++;
        if ({af_wr_en, wdf_wr_en, c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full} !== 6'b110011) begin
            n_err++; $display("FAIL single_beat1: got %b want 110011",
                {af_wr_en, wdf_wr_en, c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full});
        end
        step();
        // beat 2
        drive_c0(1'b0, 1'b1, 31'h100, db, mb);
        exp_push(1'b0, '0, db, mb);
        @(negedge clk);
        n_cmp++;
        if ({af_wr_en, wdf_wr_en, c1_af_full, c1_wdf_full, dbg_state, dbg_owner} !== 6'b011110) begin
            n_err++; $display("FAIL single_beat2: got %b want 011110",
                {af_wr_en, wdf_wr_en, c1_af_full, c1_wdf_full, dbg_state, dbg_owner});
        end
        step();
        // idle afterwards: no selection outputs
        clear_clients();
        idle_exp = {{ADDR_W{1'b0}}, {DATA_W{1'b0}}, {MASK_W{1'b1}}};
        @(negedge clk);
        n_cmp++;
        if ({af_addr_din, wdf_din, wdf_mask_din} !== idle_exp) begin
            n_err++; $display("FAIL idle_outputs: got %h want %h",
                              {af_addr_din, wdf_din, wdf_mask_din}, idle_exp);
        end
        n_cmp++;
        if ({af_wr_en, wdf_wr_en, dbg_state, dbg_last_served} !== 4'b0000) begin
            n_err++; $display("FAIL single_idle: got %b want 0000",
                              {af_wr_en, wdf_wr_en, dbg_state, dbg_last_served});
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL single_drain: got %0d want 0", exp_q.size());
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d;
        logic [MASK_W-1:0] m;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 6; i++) begin
            d = rand_data(); m = rand_mask(); a = ADDR_W'(32'h400 + i);
            drive_c0(!i[0], 1'b1, a, d, m);
            exp_push(!i[0], a, d, m);
            @(negedge clk);
            n_cmp++;
            if ({af_wr_en, wdf_wr_en} !== {!i[0], 1'b1}) begin
                n_err++; $display("FAIL b2b_cycle%0d: got %b want %b",
                                  i, {af_wr_en, wdf_wr_en}, {!i[0], 1'b1});
            end
            step();
        end
        clear_clients();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL b2b_drain: got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        logic [DATA_W-1:0] d0, d1;
        logic [MASK_W-1:0] m0, m1;
        logic [ADDR_W-1:0] a0, a1;
        logic              k, beat2;
        logic [3:0]        fexp;
        do_reset();
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            k = 1'b0;
`else
            k = i[1];           // bursts go 0,1,0 in cycle pairs
`endif
            beat2 = i[0];
            d0 = rand_data(); d1 = rand_data(); m0 = rand_mask(); m1 = rand_mask();
            a0 = ADDR_W'(32'h200 + i); a1 = ADDR_W'(32'h300 + i);
            // the non-owner keeps holding beat 1
            drive_c0(!(beat2 && !k), 1'b1, a0, d0, m0);
            drive_c1(!(beat2 && k), 1'b1, a1, d1, m1);
            if (k) exp_push(!beat2, a1, d1, m1);
            else   exp_push(!beat2, a0, d0, m0);
            fexp = k ? 4'b1100 : 4'b0011;
            @(negedge clk);
            n_cmp++;
            if ({c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full} !== fexp) begin
                n_err++; $display("FAIL arb_fulls_c%0d: got %b want %b", i,
                    {c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full}, fexp);
            end
            n_cmp++;
            if ({af_wr_en, wdf_wr_en, dbg_state} !== {!beat2, 1'b1, beat2}) begin
                n_err++; $display("FAIL arb_wr_c%0d: got %b want %b", i,
                    {af_wr_en, wdf_wr_en, dbg_state}, {!beat2, 1'b1, beat2});
            end
            if (beat2) begin
                n_cmp++;
                if (dbg_owner !== k) begin
                    n_err++; $display("FAIL arb_owner_c%0d: got %b want %b", i, dbg_owner, k);
                end
            end
            step();
        end
        // client 0 drops: client 1 now gets a burst
        clear_clients();
        d1 = rand_data(); m1 = rand_mask();
        drive_c1(1'b1, 1'b1, 31'h3F0, d1, m1);
        exp_push(1'b1, 31'h3F0, d1, m1);
        @(negedge clk);
        n_cmp++;
        if ({af_wr_en, wdf_wr_en, c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full} !== 6'b111100) begin
            n_err++; $display("FAIL arb_c1_alone: got %b want 111100",
                {af_wr_en, wdf_wr_en, c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full});
        end
        step();
        d1 = rand_data(); m1 = rand_mask();
        drive_c1(1'b0, 1'b1, 31'h3F0, d1, m1);
        exp_push(1'b0, '0, d1, m1);
        step();
        clear_clients();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL arb_drain: got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_full_stall();
        logic [DATA_W-1:0] d;
        logic [MASK_W-1:0] m;
        d = rand_data(); m = rand_mask();
        // beat 1 blocked by af_full
        af_full = 1'b1;
        drive_c0(1'b1, 1'b1, 31'h500, d, m);
        @(negedge clk);
        n_cmp++;
        if ({af_wr_en, wdf_wr_en, c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full} !== 6'b001011) begin
            n_err++; $display("FAIL stall_af_full: got %b want 001011",
                {af_wr_en, wdf_wr_en, c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full});
        end
        step();
        af_full = 1'b0;
        exp_push(1'b1, 31'h500, d, m);
        step();
        // beat 2 held off by wdf_full while client 1 requests
        d = rand_data(); m = rand_mask();
        drive_c0(1'b0, 1'b1, 31'h500, d, m);
        drive_c1(1'b1, 1'b1, 31'h600, rand_data(), rand_mask());
        wdf_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({af_wr_en, wdf_wr_en, dbg_state, dbg_owner,
                 c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full} !== 8'b00100111) begin
                n_err++; $display("FAIL stall_beat2_%0d: got %b want 00100111", i,
                    {af_wr_en, wdf_wr_en, dbg_state, dbg_owner,
                     c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full});
            end
            step();
        end
        wdf_full = 1'b0;
        exp_push(1'b0, '0, d, m);
        @(negedge clk);
        n_cmp++;
        if ({af_wr_en, wdf_wr_en} !== 2'b01) begin
            n_err++; $display("FAIL stall_release: got %b want 01", {af_wr_en, wdf_wr_en});
        end
        step();
        // client 1 granted next
        drive_c0(1'b0, 1'b0, '0, '0, '0);
        d = rand_data(); m = rand_mask();
        drive_c1(1'b1, 1'b1, 31'h600, d, m);
        exp_push(1'b1, 31'h600, d, m);
        @(negedge clk);
        n_cmp++;
        if ({af_wr_en, wdf_wr_en, c1_af_full, c1_wdf_full} !== 4'b1100) begin
            n_err++; $display("FAIL stall_c1_grant: got %b want 1100",
                              {af_wr_en, wdf_wr_en, c1_af_full, c1_wdf_full});
        end
        step();
        d = rand_data(); m = rand_mask();
        drive_c1(1'b0, 1'b1, 31'h600, d, m);
        exp_push(1'b0, '0, d, m);
        step();
        clear_clients();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL stall_drain: got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_proto_err();
        logic [DATA_W-1:0] d;
        logic [MASK_W-1:0] m;
        d = rand_data(); m = rand_mask();
        drive_c0(1'b1, 1'b1, 31'h700, d, m);
        exp_push(1'b1, 31'h700, d, m);
        step();
        // owner raises af_wr_en in beat 2: still a data-only write
        d = rand_data(); m = rand_mask();
        drive_c0(1'b1, 1'b1, 31'h701, d, m);
        exp_push(1'b0, '0, d, m);
        @(negedge clk);
        n_cmp++;
        if ({af_wr_en, wdf_wr_en, proto_err} !== 3'b010) begin
            n_err++; $display("FAIL perr_beat: got %b want 010", {af_wr_en, wdf_wr_en, proto_err});
        end
        step();
        clear_clients();
        for (int i = 0; i < 3; i++) begin
            // a clean client-1 burst does not clear the flag
            d = rand_data(); m = rand_mask();
            if (i < 2) begin
                drive_c1(!i[0], 1'b1, 31'h710, d, m);
                exp_push(!i[0], 31'h710, d, m);
            end else begin
                clear_clients();
            end
            @(negedge clk);
            n_cmp++;
            if (proto_err !== 1'b1) begin
                n_err++; $display("FAIL perr_sticky_%0d: got %b want 1", i, proto_err);
            end
            step();
        end
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++; $display("FAIL perr_clear: got %b want 0", proto_err);
        end
        step();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL perr_drain: got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [DATA_W-1:0] d;
        logic [MASK_W-1:0] m;
        d = rand_data(); m = rand_mask();
        drive_c0(1'b1, 1'b1, 31'h800, d, m);
        exp_push(1'b1, 31'h800, d, m);
        step();
        // stalled beat 2 with stray af_wr_en sets proto_err
        wdf_full = 1'b1;
        drive_c0(1'b1, 1'b1, 31'h800, rand_data(), rand_mask());
        step();
        drive_c0(1'b0, 1'b1, 31'h800, rand_data(), rand_mask());
        @(negedge clk);
        n_cmp++;
        if ({proto_err, dbg_state, af_wr_en, wdf_wr_en} !== 4'b1100) begin
            n_err++; $display("FAIL mid_pre_reset: got %b want 1100",
                              {proto_err, dbg_state, af_wr_en, wdf_wr_en});
        end
        step();
        // reset lands in BEAT2 with beat 2 otherwise acceptable
        wdf_full = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({af_wr_en, wdf_wr_en, proto_err, dbg_state,
             c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full} !== 8'b00001111) begin
            n_err++; $display("FAIL mid_reset: got %b want 00001111",
                {af_wr_en, wdf_wr_en, proto_err, dbg_state,
                 c0_af_full, c0_wdf_full, c1_af_full, c1_wdf_full});
        end
        step();
        rst_n = 1'b1;
        clear_clients();
        step();
        // fresh beat 1
        d = rand_data(); m = rand_mask();
        drive_c0(1'b1, 1'b1, 31'h810, d, m);
        exp_push(1'b1, 31'h810, d, m);
        @(negedge clk);
        n_cmp++;
        if ({af_wr_en, wdf_wr_en, dbg_state} !== 3'b110) begin
            n_err++; $display("FAIL mid_fresh: got %b want 110", {af_wr_en, wdf_wr_en, dbg_state});
        end
        step();
        d = rand_data(); m = rand_mask();
        drive_c0(1'b0, 1'b1, 31'h810, d, m);
        exp_push(1'b0, '0, d, m);
        step();
        clear_clients();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL mid_drain: got %0d want 0", exp_q.size());
        end
    endtask

    // -----------------------------------------------------------------------
    // Sequence and report
    // -----------------------------------------------------------------------
    initial begin
        af_full = 1'b0;
        wdf_full = 1'b0;
        clear_clients();
        #1;
        test_reset();
        test_single_client();
        test_back_to_back();
        test_round_robin();
        test_full_stall();
        test_proto_err();
        test_reset_mid_burst();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddr2_write_arbiter.md
DDR2_WRITE_ARBITER -- requirements
Module: ddr2_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 31, meaning DDR2 address FIFO word width.
REQ-002 SHALL have parameter DATA_W, default 128, meaning DDR2 write-data FIFO word width.
REQ-003 SHALL have parameter MASK_W, default 16, meaning byte-mask width (DATA_W/8).
REQ-004 SHALL have port clk, input, 1, the only clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have, for each client k in {0,1}, the following inputs:
- cK_af_addr_din, input, ADDR_W.
- cK_af_wr_en, input, 1.
- cK_wdf_din, input, DATA_W.
- cK_wdf_mask_din, input, MASK_W.
- cK_wdf_wr_en, input, 1.
REQ-007 SHALL have, for each client k, outputs cK_af_full and cK_wdf_full, each 1 bit: the full view presented to that client.
REQ-008 SHALL have inputs af_full and wdf_full, each 1 bit, from the DDR2 FIFOs.
REQ-009 SHALL have the following outputs to the DDR2 FIFOs:
- af_addr_din, ADDR_W.
- af_wr_en, 1.
- wdf_din, DATA_W.
- wdf_mask_din, MASK_W.
- wdf_wr_en, 1.
REQ-010 SHALL have output proto_err, 1: sticky protocol-violation flag.

Function
REQ-011 SHALL treat a client burst as two beats:
- Beat 1: af_wr_en=1 and wdf_wr_en=1 in the same cycle.
- Beat 2: wdf_wr_en=1 with af_wr_en=0.
- Client 0 is the frame-fill engine; client 1 is the line/rectangle engine.
REQ-012 SHALL implement states IDLE and BEAT2, plus an owner register (1 bit) and a last_served register (1 bit).
REQ-013 In IDLE, SHALL define a request from client k as cK_af_wr_en & cK_wdf_wr_en; af_wr_en alone is not a request.
REQ-014 In IDLE with both clients requesting, SHALL select the winner per REQ-030/031; with one requester, SHALL select that requester.
REQ-015 SHALL forward the selected client's addr, data, and mask to the DDR2 outputs combinationally, with zero-cycle latency.
REQ-016 SHALL pass true af_full/wdf_full to the selected or owning client, and force cK_af_full=cK_wdf_full=1 to the other client.
REQ-017 SHALL accept beat 1 when !af_full && !wdf_full. On acceptance:
- Drive af_wr_en=wdf_wr_en=1 for that cycle.
- Register owner <= winner.
- Go to BEAT2.
REQ-018 SHALL drive af_wr_en=wdf_wr_en=0 whenever no write is accepted; DDR2 never sees a write while full.
REQ-019 In BEAT2, SHALL route only the owner and accept when owner wdf_wr_en && !af_full && !wdf_full. On acceptance:
- Drive wdf_wr_en=1 and af_wr_en=0.
- Set last_served <= owner.
- Go to IDLE.
REQ-020 In BEAT2, SHALL keep the grant locked regardless of the non-owner's requests or full stalls of any length.
REQ-021 If the owner asserts af_wr_en in BEAT2, SHALL set proto_err=1 (sticky) and treat the cycle as beat 2 when its wdf_wr_en is accepted.
REQ-022 With no selection, SHALL drive af_addr_din=0, wdf_din=0, and wdf_mask_din=all ones.
REQ-023 Back-to-back bursts SHALL be allowed: IDLE beat 1 may be accepted in the cycle after a beat-2 acceptance.
REQ-024 The minimum burst time SHALL be 2 cycles; sustained single-client throughput is one beat per cycle.

Reset
REQ-025 On rst_n=0, SHALL asynchronously force state=IDLE, owner=0, last_served=1, and proto_err=0.
REQ-026 While rst_n=0, SHALL hold af_wr_en=wdf_wr_en=0 and present cK_af_full=cK_wdf_full=1 to both clients.
REQ-027 Reset mid-burst (in BEAT2) SHALL abandon the burst with no further DDR2 write.
REQ-028 Release of rst_n SHALL take effect on the next rising clk edge after deassertion.

Configuration
REQ-029 SHALL use macro ARB_FIXED_PRIORITY_EN.
REQ-030 With ARB_FIXED_PRIORITY_EN defined, SHALL always let client 0 win simultaneous requests; last_served is unused.
REQ-031 Without ARB_FIXED_PRIORITY_EN, SHALL use round-robin: on simultaneous requests the winner is ~last_served.

Verification
REQ-032 Client 0 only, addr=0x100, data=A then B, fulls=0 -> af_wr_en=1,wdf_wr_en=1 at cycle N with addr 0x100/A; wdf_wr_en=1 with B at N+1; c1 fulls=1 throughout.
REQ-033 Both request at cycle 0, round-robin, after reset -> client 0 bursts cycles 0-1, client 1 bursts cycles 2-3, client 0 bursts cycles 4-5.
REQ-034 Same stimulus with ARB_FIXED_PRIORITY_EN -> client 0 holds every burst; client 1 sees fulls=1 until client 0 drops requests.
REQ-035 wdf_full=1 for 5 cycles during BEAT2 with client 1 requesting -> no DDR2 writes for those cycles, owner unchanged, then beat 2 issues, then client 1 is granted.
REQ-036 rst_n pulled low in BEAT2 -> outputs go quiet immediately (same cycle), state=IDLE, proto_err=0; next request starts a fresh beat 1.
REQ-037 Owner asserts af_wr_en in BEAT2 -> proto_err=1 from the next cycle and stays 1 until reset.
